// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared definitions for the SPI master and its byte stash
// Purpose: transfer-sequencer state encoding, byte width, default stash depth
//          and the ENABLE active level, shared by spi_stash and the SPI master.
// Ports:   none (package).
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } spi_state_t;

    localparam int   BYTE_W        = 8;
    localparam int   DEFAULT_DEPTH = 16;

    // The master treats ENABLE as an active-low transfer request.
    localparam logic ENABLE_ACTIVE = 1'b0;

endpackage

// File: rtl/spi_stash_ram.sv
// rtl/spi_stash_ram.sv - single-write, registered-read byte array
// Purpose: DEPTH x BYTE_W storage. The array itself is never reset; only the
//          read register is, so the read port shows 0 after reset.
// Ports:   clk, rst (async, active-high), we/waddr/wdata write port,
//          raddr read index, rdata registered read data (1-cycle latency).
module spi_stash_ram
    import spi_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a write on cycle N reaches rdata no earlier than N+2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_stash.sv
// rtl/spi_stash.sv - TX/RX byte stash and transfer sequencer for the SPI master
// Purpose: holds host-written TX bytes and presents tx[stash_ptr] on MOSI_data,
//          captures each completed MISO byte into rx[stash_ptr], and drives the
//          active-low ENABLE for LEN (clamped to DEPTH) bytes, pulsing DONE at end.
// Optional feature: SPI_STASH_PTR_CHECK_EN - compare stash_ptr against the
//          internal byte count on every BYTE_DONE; a mismatch sets sticky ERR,
//          drops the rx write and ends the transfer. Undefined: ERR tied 0.
// Ports:   CTRL_CLK, RST (async, active-high);
//          host side HOST_WR/HOST_WDATA/HOST_CLR, HOST_RADDR/HOST_RDATA;
//          control START/LEN, status BUSY/DONE/ERR;
//          master side ENABLE, stash_ptr, MOSI_data, MISO_data, BYTE_DONE.
module spi_stash
    import spi_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              CTRL_CLK,
    input  logic              RST,
    input  logic              HOST_WR,
    input  logic [BYTE_W-1:0] HOST_WDATA,
    input  logic              HOST_CLR,
    input  logic [AW-1:0]     HOST_RADDR,
    output logic [BYTE_W-1:0] HOST_RDATA,
    input  logic              START,
    input  logic [7:0]        LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              ENABLE,
    input  logic [7:0]        stash_ptr,
    output logic [BYTE_W-1:0] MOSI_data,
    input  logic [BYTE_W-1:0] MISO_data,
    input  logic              BYTE_DONE
);

    // len_q needs 9 bits so that DEPTH=256 fits.
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    spi_state_t  state;
    spi_state_t  next_state;
    logic [AW-1:0] wr_ptr;
    logic [7:0]  byte_cnt;
    logic [8:0]  len_q;
    logic [8:0]  len_clamped;
    logic        busy;
    logic        byte_evt;
    logic        last_byte;
    logic        ptr_bad;
    logic        tx_we;
    logic        rx_we;

    assign busy        = (state != IDLE);
    assign byte_evt    = (state == RUN) && BYTE_DONE;
    assign last_byte   = ({1'b0, byte_cnt} == (len_q - 9'd1));
    assign len_clamped = ({1'b0, LEN} > DEPTH_L) ? DEPTH_L : {1'b0, LEN};

`ifdef SPI_STASH_PTR_CHECK_EN
    logic err_q;

    assign ptr_bad = (stash_ptr != byte_cnt);

    always_ff @(posedge CTRL_CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (byte_evt && ptr_bad) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    // Only the low AW bits index the arrays when the pointer is trusted.
    logic unused_ptr_hi;

    assign unused_ptr_hi = ^stash_ptr;
    assign ptr_bad       = 1'b0;
    assign ERR           = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge CTRL_CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (START) begin
                    next_state = (LEN == 8'd0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (BYTE_DONE && (ptr_bad || last_byte)) begin
                    next_state = FINISH;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transfer length and progress counter.
    always_ff @(posedge CTRL_CLK or posedge RST) begin
        if (RST) begin
            len_q    <= '0;
            byte_cnt <= '0;
        end else if ((state == IDLE) && START && (LEN != 8'd0)) begin
            len_q    <= len_clamped;
            byte_cnt <= '0;
        end else if (byte_evt) begin
            byte_cnt <= byte_cnt + 8'd1;
        end
    end

    // Host write pointer: clear wins over write; writes during a transfer are dropped.
    assign tx_we = HOST_WR && !HOST_CLR && !busy;

    always_ff @(posedge CTRL_CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
        end else if (HOST_CLR) begin
            wr_ptr <= '0;
        end else if (tx_we) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    assign rx_we = byte_evt && !ptr_bad;

    spi_stash_ram #(.DEPTH(DEPTH)) u_tx_ram (
        .clk   (CTRL_CLK),
        .rst   (RST),
        .we    (tx_we),
        .waddr (wr_ptr),
        .wdata (HOST_WDATA),
        .raddr (stash_ptr[AW-1:0]),
        .rdata (MOSI_data)
    );

    spi_stash_ram #(.DEPTH(DEPTH)) u_rx_ram (
        .clk   (CTRL_CLK),
        .rst   (RST),
        .we    (rx_we),
        .waddr (stash_ptr[AW-1:0]),
        .wdata (MISO_data),
        .raddr (HOST_RADDR),
        .rdata (HOST_RDATA)
    );

    // Decoded from the state register so reset raises ENABLE immediately.
    assign ENABLE = (state == RUN) ? ENABLE_ACTIVE : ~ENABLE_ACTIVE;
    assign BUSY   = busy;
    assign DONE   = (state == FINISH);

endmodule
